uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
Upstream stage of the SOML decoder. Collects a byte stream from the UART receiver (rx_data_ready/rx_data) into one complete frame: 16 complex H entries and 8 complex Y entries, protected by an XOR checksum. After the checksum passes, it replays the frame to the decoder top as a start pulse followed by H_in_valid/Y_in_valid word streams. The stream timing matches the decoder's IDLE->LOAD handshake.

Parameters:
N, 32, width of each real or imaginary component (two's complement, Q-format untouched).
SYNC_BYTE, 8'hA5, frame header byte.
TIMEOUT_CYC, 208333, maximum clk cycles allowed between two bytes inside a frame (4 byte-times at 9600 baud, 50 MHz).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
rx_data_ready  in  1  one-cycle strobe, rx_data valid.
rx_data  in  8  received byte.
load_ready  in  1  decoder can accept a new frame (tie 1 if unused).
start  out  1  one-cycle pulse to decoder start.
H_in_valid  out  1  H word strobe.
H_in_r  out  N  H real part.
H_in_i  out  N  H imaginary part.
Y_in_valid  out  1  Y word strobe.
Y_in_r  out  N  Y real part.
Y_in_i  out  N  Y imaginary part.
frame_ok  out  1  one-cycle pulse, checksum passed (coincides with start).
frame_err  out  1  one-cycle pulse, checksum mismatch or inter-byte timeout.
busy  out  1  high whenever state != S_HUNT.

Behaviour:
- Reset: all outputs 0; state S_HUNT; byte/word counters, checksum accumulator and timeout counter all 0. Frame buffer contents are don't-care.
- Frame format, 194 bytes: SYNC_BYTE, 192 payload bytes, 1 checksum byte.
  - Payload is 24 complex samples, each sent as real then imag. Each component is N/8 bytes, MSB first.
  - Samples 0..15 are H, row-major (r0c0, r0c1, ..., r3c3).
  - Samples 16..23 are Y: y1[0..3], then y2[0..3].
  - Checksum = XOR of all 192 payload bytes. The header is excluded.
- States:
  - S_HUNT: on a strobe with rx_data==SYNC_BYTE go to S_RECV; clear the checksum and byte counter. Other bytes are discarded silently.
  - S_RECV: each strobe shifts the byte into the current component register and XORs it into the checksum. After 192 payload bytes, the next strobe is the checksum byte: go to S_CHK and latch the comparison.
  - S_CHK, one cycle:
    - mismatch: pulse frame_err, go to S_HUNT.
    - match: go to S_WAIT.
  - S_WAIT: when load_ready=1, assert start and frame_ok for one cycle, go to S_EMIT with emit counter e=0.
  - S_EMIT, 16 cycles, e=0..15:
    - H_in_valid=1 with H word e.
    - Y_in_valid=1 with Y word e for e<8; otherwise Y_in_valid=0.
    - After e=15, go to S_HUNT.
- Latency with load_ready=1: checksum byte strobe sampled at edge t -> S_CHK in cycle t+1 -> start/frame_ok in cycle t+2 -> H_in_valid in cycles t+3..t+18, Y_in_valid in cycles t+3..t+10.
- Output hold: data outputs hold their last value when their valid is low; valids are never asserted outside S_EMIT.
- Timeout (S_RECV only): the counter resets on every strobe. Reaching TIMEOUT_CYC pulses frame_err and returns to S_HUNT; the partial frame is dropped.
- Byte strobes arriving in S_CHK, S_WAIT or S_EMIT are ignored. They are not buffered and not counted, and no error is raised.
- A SYNC_BYTE value inside the payload is treated as data; there is no resync mid-frame.
- rst asserted mid-frame or mid-emit: at the next edge go to S_HUNT and drop all valids to 0. No partial stream resumes.
- Word assembly: component = {prev[N-9:0], rx_data}, written into buffer slot [sample][re/im] on the last byte of the component.

Test Plan:
- Good frame: 0x13 then header, H[k].r=k<<22, H[k].i=-(k<<22), Y[j].r=(j+1)<<22, Y[j].i=0, correct checksum -> one start+frame_ok pulse; H_in_valid for 16 consecutive cycles with H_in_r=0,0x400000,...,0x3C00000; Y_in_valid for the first 8 of those with matching values; busy drops after e=15.
- Checksum off by one bit -> frame_err pulse 1 cycle after the checksum strobe; no start, no valids; next good frame is accepted.
- Stall after 50 payload bytes with no strobe for TIMEOUT_CYC cycles -> frame_err pulse, state S_HUNT; a following good frame decodes correctly.
- Good frame with load_ready held 0 for 100 cycles -> no start until load_ready=1; start follows 1 cycle after it rises; bytes sent during the wait are ignored.
- rst pulsed during S_EMIT at e=5 -> valids 0 from the next cycle, all outputs back to reset values, busy=0.
- Payload containing 0xA5 bytes -> still assembled as data; values reproduced exactly.

Source files
------------

// File: rtl/uart_frame_loader_if.sv
// Byte-in / frame-out bundle between the UART receiver, the frame loader and the decoder.
// master = loader side, slave = the UART/decoder environment driving and consuming it.
interface uart_frame_loader_if #(
  parameter int N = 32
);
  logic         rx_data_ready;
  logic [7:0]   rx_data;
  logic         load_ready;
  logic         start;
  logic         H_in_valid;
  logic [N-1:0] H_in_r;
  logic [N-1:0] H_in_i;
  logic         Y_in_valid;
  logic [N-1:0] Y_in_r;
  logic [N-1:0] Y_in_i;
  logic         frame_ok;
  logic         frame_err;
  logic         busy;

  modport master (
    input  rx_data_ready, rx_data, load_ready,
    output start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
           frame_ok, frame_err, busy
  );

  modport slave (
    output rx_data_ready, rx_data, load_ready,
    input  start, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i,
           frame_ok, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Assembles a SYNC-headed, XOR-checksummed UART frame of 16 H and 8 Y complex words,
// then replays it to the decoder as start followed by H/Y valid streams.
//
// state  | meaning
// S_HUNT | discard bytes until SYNC_BYTE
// S_RECV | shift payload bytes into components, accumulate XOR, watch inter-byte timeout
// S_CHK  | one cycle: act on latched checksum comparison
// S_WAIT | hold complete frame until decoder raises load_ready
// S_EMIT | 16 cycles of H words, first 8 also carry Y words
module uart_frame_loader #(
  parameter int         N           = 32,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 208333
) (
  input logic               clk,
  input logic               rst,
  uart_frame_loader_if.master bus
);

  localparam int              BPC      = N / 8;
  localparam int              SW       = (BPC > 1) ? $clog2(BPC) : 1;
  localparam logic [SW-1:0]   SUB_LAST = SW'(BPC - 1);
  localparam logic [5:0]      NCOMP    = 6'd48;
  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_HUNT, S_RECV, S_CHK, S_WAIT, S_EMIT} state_t;

  state_t        state_q, state_d;
  logic [5:0]    slot_q, slot_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    emit_q, emit_d;
  logic          match_q, match_d;
  logic [N-9:0]  comp_q, comp_d;
  logic [N-1:0]  h_r_q, h_i_q, y_r_q, y_i_q;

  // Component slots: 2*sample + (0 real, 1 imag); H in 0..31, Y in 32..47
  logic [N-1:0]  buf_q [0:47];
  logic [N-1:0]  comp_full;
  logic          buf_we;
  logic          start_c, err_c, h_valid, y_valid;
  logic [5:0]    h_idx_r, h_idx_i, y_idx_r, y_idx_i;

  assign comp_full = {comp_q, bus.rx_data};
  assign h_idx_r   = {1'b0, emit_q, 1'b0};
  assign h_idx_i   = {1'b0, emit_q, 1'b1};
  assign y_idx_r   = {2'b10, emit_q[2:0], 1'b0};
  assign y_idx_i   = {2'b10, emit_q[2:0], 1'b1};

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sub_d   = sub_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    emit_d  = emit_q;
    match_d = match_q;
    comp_d  = comp_q;
    buf_we  = 1'b0;
    start_c = 1'b0;
    err_c   = 1'b0;
    h_valid = 1'b0;
    y_valid = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (bus.rx_data_ready && bus.rx_data == SYNC_BYTE) begin
          state_d = S_RECV;
          slot_d  = '0;
          sub_d   = '0;
          csum_d  = '0;
          tmo_d   = TMO_LOAD;
        end
      end
      S_RECV: begin
        if (bus.rx_data_ready) begin
          tmo_d = TMO_LOAD;
          if (slot_q == NCOMP) begin
            match_d = (bus.rx_data == csum_q);
            state_d = S_CHK;
          end else begin
            comp_d = comp_full[N-9:0];
            csum_d = csum_q ^ bus.rx_data;
            if (sub_q == SUB_LAST) begin
              buf_we = 1'b1;
              sub_d  = '0;
              slot_d = slot_q + 6'd1;
            end else begin
              sub_d = sub_q + SW'(1);
            end
          end
        end else if (tmo_q == '0) begin
          err_c   = 1'b1;
          state_d = S_HUNT;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_CHK: begin
        if (match_q) begin
          state_d = S_WAIT;
        end else begin
          err_c   = 1'b1;
          state_d = S_HUNT;
        end
      end
      S_WAIT: begin
        if (bus.load_ready) begin
          start_c = 1'b1;
          emit_d  = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        h_valid = 1'b1;
        y_valid = ~emit_q[3];
        emit_d  = emit_q + 4'd1;
        if (emit_q == 4'd15) state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HUNT;
      slot_q  <= '0;
      sub_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      emit_q  <= '0;
      match_q <= 1'b0;
      comp_q  <= '0;
      h_r_q   <= '0;
      h_i_q   <= '0;
      y_r_q   <= '0;
      y_i_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sub_q   <= sub_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      emit_q  <= emit_d;
      match_q <= match_d;
      comp_q  <= comp_d;
      if (h_valid) begin
        h_r_q <= buf_q[h_idx_r];
        h_i_q <= buf_q[h_idx_i];
      end
      if (y_valid) begin
        y_r_q <= buf_q[y_idx_r];
        y_i_q <= buf_q[y_idx_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[slot_q] <= comp_full;
  end

  // Data outputs show the live word while valid, otherwise the last emitted word
  assign bus.H_in_r     = h_valid ? buf_q[h_idx_r] : h_r_q;
  assign bus.H_in_i     = h_valid ? buf_q[h_idx_i] : h_i_q;
  assign bus.Y_in_r     = y_valid ? buf_q[y_idx_r] : y_r_q;
  assign bus.Y_in_i     = y_valid ? buf_q[y_idx_i] : y_i_q;
  assign bus.H_in_valid = h_valid;
  assign bus.Y_in_valid = y_valid;
  assign bus.start      = start_c;
  assign bus.frame_ok   = start_c;
  assign bus.frame_err  = err_c;
  assign bus.busy       = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized frame-level bench for uart_frame_loader: builds byte frames from sample
// arrays and compares the emitted H/Y streams, pulses and latencies against them.
module tb_uart_frame_loader;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_frame_loader_if #(.N(32)) bus();

  uart_frame_loader #(.N(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] hr[16], hi[16], yr[8], yi[8];
  logic [7:0]  tx_q[$];
  logic [63:0] hq[$], yq[$];
  int n_start, n_ok, n_err, n_okmis;
  int start_cyc, err_cyc, h_first, h_last, y_first, y_last, strobe_cyc, lr_cyc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.start) begin n_start++; start_cyc = cyc; end
    if (bus.frame_ok) n_ok++;
    if (bus.frame_ok != bus.start) n_okmis++;
    if (bus.frame_err) begin n_err++; err_cyc = cyc; end
    if (bus.H_in_valid) begin
      if (hq.size() == 0) h_first = cyc;
      h_last = cyc;
      hq.push_back({bus.H_in_r, bus.H_in_i});
    end
    if (bus.Y_in_valid) begin
      if (yq.size() == 0) y_first = cyc;
      y_last = cyc;
      yq.push_back({bus.Y_in_r, bus.Y_in_i});
    end
  end

  task automatic clear_mon();
    n_start = 0; n_ok = 0; n_err = 0; n_okmis = 0;
    start_cyc = -100; err_cyc = -100; h_first = -100; h_last = -100;
    y_first = -100; y_last = -100;
    hq.delete(); yq.delete();
  endtask

  // Component c: sample c/2, real for even c, imag for odd c; samples 16..23 are Y
  function automatic logic [31:0] comp_val(input int c);
    int s;
    s = c / 2;
    if (s < 16) return (c % 2 == 1) ? hi[s] : hr[s];
    return (c % 2 == 1) ? yi[s-16] : yr[s-16];
  endfunction

  task automatic build_frame(input logic [7:0] cs_flip);
    logic [7:0]  cs;
    logic [31:0] v;
    tx_q.delete();
    tx_q.push_back(8'hA5);
    cs = 8'h00;
    for (int c = 0; c < 48; c++) begin
      v = comp_val(c);
      for (int b = 3; b >= 0; b--) begin
        tx_q.push_back(v[8*b +: 8]);
        cs = cs ^ v[8*b +: 8];
      end
    end
    tx_q.push_back(cs ^ cs_flip);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) begin hr[k] = $urandom; hi[k] = $urandom; end
    for (int k = 0; k < 8; k++)  begin yr[k] = $urandom; yi[k] = $urandom; end
    hr[3][31:24] = 8'hA5;
    yi[7][7:0]   = 8'hA5;
    hi[$urandom_range(0, 15)][15:8] = 8'hA5;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_data_ready = 1'b1;
    @(posedge clk); #1;
    strobe_cyc = cyc;
    bus.rx_data_ready = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_range(input int lo, input int hi_x);
    for (int i = lo; i < hi_x; i++) send_byte(tx_q[i]);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400; k++) begin
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
    check_val({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic verify(input string tag, input bit chk_lat);
    check_val({tag, "_start"}, 64'(n_start), 64'd1);
    check_val({tag, "_ok"}, 64'(n_ok), 64'd1);
    check_val({tag, "_okstart"}, 64'(n_okmis), 64'd0);
    check_val({tag, "_err"}, 64'(n_err), 64'd0);
    check_val({tag, "_hcount"}, 64'(hq.size()), 64'd16);
    check_val({tag, "_ycount"}, 64'(yq.size()), 64'd8);
    if (chk_lat) check_val({tag, "_lat_start"}, 64'(start_cyc - strobe_cyc), 64'd1);
    check_val({tag, "_lat_h"}, 64'(h_first - start_cyc), 64'd1);
    check_val({tag, "_hspan"}, 64'(h_last - h_first), 64'd15);
    check_val({tag, "_yalign"}, 64'(y_first - h_first), 64'd0);
    check_val({tag, "_yspan"}, 64'(y_last - y_first), 64'd7);
    for (int k = 0; k < 16; k++) check_val({tag, "_h"}, hq[k], {hr[k], hi[k]});
    for (int k = 0; k < 8; k++)  check_val({tag, "_y"}, yq[k], {yr[k], yi[k]});
    check_val({tag, "_hold_h"}, {bus.H_in_r, bus.H_in_i}, {hr[15], hi[15]});
    check_val({tag, "_hold_y"}, {bus.Y_in_r, bus.Y_in_i}, {yr[7], yi[7]});
  endtask

  task automatic good_frame(input string tag);
    rand_frame();
    clear_mon();
    build_frame(8'h00);
    send_range(0, tx_q.size());
    wait_idle(tag);
    verify(tag, 1'b1);
  endtask

  initial begin
    int d;
    bus.rx_data_ready = 1'b0;
    bus.rx_data = 8'h00;
    bus.load_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_start", 64'(bus.start), 64'd0);
    check_val("rst_err", 64'(bus.frame_err), 64'd0);
    check_val("rst_valids", 64'({bus.H_in_valid, bus.Y_in_valid}), 64'd0);
    check_val("rst_hdata", {bus.H_in_r, bus.H_in_i}, 64'd0);
    check_val("rst_ydata", {bus.Y_in_r, bus.Y_in_i}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      hr[k] = 32'(k << 22);
      hi[k] = 32'(-(k << 22));
    end
    for (int j = 0; j < 8; j++) begin
      yr[j] = 32'((j + 1) << 22);
      yi[j] = 32'd0;
    end
    clear_mon();
    build_frame(8'h00);
    send_byte(8'h13);
    send_range(0, tx_q.size());
    wait_idle("dir");
    verify("dir", 1'b1);

    for (int f = 0; f < 3; f++) good_frame("rnd");

    rand_frame();
    clear_mon();
    build_frame(8'(8'h01 << $urandom_range(0, 7)));
    send_range(0, tx_q.size());
    wait_idle("bad");
    check_val("bad_err", 64'(n_err), 64'd1);
    check_val("bad_err_lat", 64'(err_cyc - strobe_cyc), 64'd0);
    check_val("bad_start", 64'(n_start), 64'd0);
    check_val("bad_valids", 64'(hq.size() + yq.size()), 64'd0);
    good_frame("after_bad");

    rand_frame();
    clear_mon();
    build_frame(8'h00);
    send_range(0, 51);
    for (int k = 0; k < TMO + 100 && n_err == 0; k++) begin @(posedge clk); #1; end
    check_val("tmo_err", 64'(n_err), 64'd1);
    d = err_cyc - strobe_cyc;
    check_val("tmo_lat", 64'(d >= TMO - 1 && d <= TMO + 1), 64'd1);
    @(posedge clk); #1;
    check_val("tmo_busy", 64'(bus.busy), 64'd0);
    check_val("tmo_start", 64'(n_start + hq.size()), 64'd0);
    good_frame("after_tmo");

    bus.load_ready = 1'b0;
    rand_frame();
    clear_mon();
    build_frame(8'h00);
    send_range(0, tx_q.size());
    for (int i = 0; i < 10; i++) send_byte((i == 3) ? 8'hA5 : 8'($urandom));
    repeat (70) begin @(posedge clk); #1; end
    check_val("lr_nostart", 64'(n_start), 64'd0);
    check_val("lr_busy", 64'(bus.busy), 64'd1);
    check_val("lr_novalid", 64'(hq.size()), 64'd0);
    bus.load_ready = 1'b1;
    lr_cyc = cyc;
    wait_idle("lr");
    d = start_cyc - lr_cyc;
    check_val("lr_lat", 64'(d >= 0 && d <= 1), 64'd1);
    verify("lr", 1'b0);

    rand_frame();
    clear_mon();
    build_frame(8'h00);
    send_range(0, tx_q.size());
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (hq.size() >= 6) break;
    end
    check_val("mid_e5", 64'(hq.size()), 64'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_valids", 64'({bus.H_in_valid, bus.Y_in_valid}), 64'd0);
    check_val("mid_busy", 64'(bus.busy), 64'd0);
    check_val("mid_hdata", {bus.H_in_r, bus.H_in_i}, 64'd0);
    check_val("mid_ydata", {bus.Y_in_r, bus.Y_in_i}, 64'd0);
    repeat (30) @(posedge clk);
    #1;
    check_val("mid_noresume", 64'(hq.size()), 64'd6);
    check_val("mid_nostart", 64'(n_start), 64'd1);
    good_frame("after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
